// File: rtl/text_console_writer_if.sv
// Byte stream input plus text RAM port of the console writer.
// slave is the writer itself; master is the byte source / RAM side.
interface text_console_writer_if #(
    parameter int unsigned ADDR_W = 10
) ();
    logic [7:0]        char_in;
    logic              char_valid;
    logic              char_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;

    modport slave (
        input  char_in, char_valid, ram_dout,
        output char_ready, ram_addr, ram_we, ram_din
    );

    modport master (
        output char_in, char_valid, ram_dout,
        input  char_ready, ram_addr, ram_we, ram_din
    );
endinterface

// File: rtl/text_console_writer.sv
// Console writer: turns a byte stream into text RAM writes, handling cursor,
// line wrap, control codes, one-row scroll-up and full-screen clear.
module text_console_writer #(
    parameter int unsigned COLS   = 40,
    parameter int unsigned ROWS   = 25,
    parameter int unsigned ADDR_W = 10,
    parameter logic [7:0]  FILL   = 8'h20
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    text_console_writer_if.slave bus,
    output logic [5:0]           cursor_col_o,
    output logic [4:0]           cursor_row_o,
    output logic                 busy_o
);
    localparam logic [ADDR_W-1:0] LastAddr    = ADDR_W'(ROWS * COLS - 1);
    localparam logic [ADDR_W-1:0] LastRowBase = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] ColsA       = ADDR_W'(COLS);
    localparam logic [5:0]        LastCol     = 6'(COLS - 1);
    localparam logic [4:0]        LastRow     = 5'(ROWS - 1);

    typedef enum logic [2:0] {
        StClearAll,
        StIdle,
        StWrite,
        StScrollRd,
        StScrollWr,
        StClearLine,
        StConsume
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [5:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [7:0]        byte_q, byte_d;
    logic [ADDR_W-1:0] cur_addr;
    logic              is_bs;

    assign cur_addr = ADDR_W'(32'(row_q) * COLS + 32'(col_q));
    // A backspace reuses StWrite to blank the cell but must not advance the cursor.
    assign is_bs    = (byte_q == 8'h08);

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        col_d          = col_q;
        row_d          = row_q;
        byte_d         = byte_q;
        bus.char_ready = 1'b0;
        bus.ram_we     = 1'b0;
        bus.ram_addr   = '0;
        bus.ram_din    = '0;

        unique case (state_q)
            StClearAll: begin
                // Gated by reset so the port stays quiet while reset is held.
                bus.ram_we   = resetn_i;
                bus.ram_din  = resetn_i ? FILL : 8'h00;
                bus.ram_addr = ptr_q;
                if (ptr_q == LastAddr) begin
                    ptr_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = StIdle;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end

            StIdle: begin
                bus.char_ready = 1'b1;
                if (bus.char_valid) begin
                    byte_d = bus.char_in;
                    if (bus.char_in >= 8'h20 && bus.char_in <= 8'h7E) begin
                        state_d = StWrite;
                    end else begin
                        case (bus.char_in)
                            8'h0D: begin
                                col_d   = '0;
                                state_d = StConsume;
                            end
                            8'h0A: begin
                                col_d = '0;
                                if (row_q != LastRow) begin
                                    row_d   = row_q + 5'd1;
                                    state_d = StConsume;
                                end else begin
                                    ptr_d   = ColsA;
                                    state_d = StScrollRd;
                                end
                            end
                            8'h08: begin
                                if (col_q != 6'd0) begin
                                    col_d   = col_q - 6'd1;
                                    state_d = StWrite;
                                end else begin
                                    state_d = StConsume;
                                end
                            end
                            8'h0C: begin
                                ptr_d   = '0;
                                state_d = StClearAll;
                            end
                            default: state_d = StConsume;
                        endcase
                    end
                end
            end

            StWrite: begin
                bus.ram_we   = 1'b1;
                bus.ram_addr = cur_addr;
                bus.ram_din  = is_bs ? FILL : byte_q;
                state_d      = StIdle;
                if (!is_bs) begin
                    if (col_q != LastCol) begin
                        col_d = col_q + 6'd1;
                    end else begin
                        col_d = '0;
                        if (row_q != LastRow) begin
                            row_d = row_q + 5'd1;
                        end else begin
                            ptr_d   = ColsA;
                            state_d = StScrollRd;
                        end
                    end
                end
            end

            StScrollRd: begin
                bus.ram_addr = ptr_q;
                state_d      = StScrollWr;
            end

            StScrollWr: begin
                // ram_dout holds the cell one row below the destination.
                bus.ram_we   = 1'b1;
                bus.ram_addr = ptr_q - ColsA;
                bus.ram_din  = bus.ram_dout;
                if (ptr_q == LastAddr) begin
                    ptr_d   = LastRowBase;
                    state_d = StClearLine;
                end else begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    state_d = StScrollRd;
                end
            end

            StClearLine: begin
                bus.ram_we   = 1'b1;
                bus.ram_addr = ptr_q;
                bus.ram_din  = FILL;
                if (ptr_q == LastAddr) begin
                    ptr_d   = '0;
                    state_d = StIdle;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end

            StConsume: state_d = StIdle;

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= StClearAll;
            ptr_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            byte_q  <= byte_d;
        end
    end

    assign cursor_col_o = col_q;
    assign cursor_row_o = row_q;
    assign busy_o       = (state_q != StIdle);
endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: RAM model plus a write scoreboard.
`timescale 1ns/1ps
module tb_text_console_writer;
    localparam int unsigned COLS   = 40;
    localparam int unsigned ROWS   = 25;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned CELLS  = 1000;
    localparam logic [7:0]  FILL   = 8'h20;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [5:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    text_console_writer_if #(.ADDR_W(ADDR_W)) bus ();

    text_console_writer #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .ADDR_W(ADDR_W),
        .FILL  (FILL)
    ) dut (
        .clk_i       (clk),
        .resetn_i    (resetn),
        .bus         (bus),
        .cursor_col_o(cursor_col),
        .cursor_row_o(cursor_row),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Text RAM: synchronous write, registered read.
    logic [7:0] mem [1024];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] exp_mem [1024];
    int         errors = 0;
    int         checks = 0;
    int         exp_col = 0;
    int         exp_row = 0;
    wr_t        mon_w;

    task automatic push_wr(input int a, input logic [7:0] d);
        wr_t w;
        w.addr = ADDR_W'(a);
        w.data = d;
        exp_q.push_back(w);
        exp_mem[a] = d;
    endtask

    always @(negedge clk) begin
        if (resetn && bus.ram_we) begin
            checks++;
            if (bus.char_ready !== 1'b0) begin
                errors++;
                $display("FAIL we_in_idle: ram_we=1 with char_ready=%b, required char_ready=0",
                         bus.char_ready);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: write addr=%0d data=%h, required no write",
                         bus.ram_addr, bus.ram_din);
            end else begin
                mon_w = exp_q.pop_front();
                if (bus.ram_addr !== mon_w.addr || bus.ram_din !== mon_w.data) begin
                    errors++;
                    $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.ram_addr, bus.ram_din, mon_w.addr, mon_w.data);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.char_in    = b;
        bus.char_valid = 1'b1;
        while (!bus.char_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.char_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: char_ready=0 after %0d cycles, required 1", n);
        end
        @(posedge clk);
        @(negedge clk);
        bus.char_valid = 1'b0;
    endtask

    // Counts cycles with char_ready low, starting at the current negedge.
    task automatic count_low(input int limit, output int n);
        n = 0;
        while (!bus.char_ready && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        bus.char_valid = 1'b0;
        bus.char_in    = 8'h00;
        resetn         = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.char_ready !== 1'b0 || bus.ram_we !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctl: ready=%b we=%b busy=%b, required 0 0 1",
                     bus.char_ready, bus.ram_we, busy);
        end
        checks++;
        if (bus.ram_addr !== '0 || bus.ram_din !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus: addr=%0d din=%h, required 0 00", bus.ram_addr, bus.ram_din);
        end
        checks++;
        if (cursor_col !== 6'd0 || cursor_row !== 5'd0) begin
            errors++;
            $display("FAIL reset_cursor: %0d/%0d, required 0/0", cursor_row, cursor_col);
        end
        for (int a = 0; a < int'(CELLS); a++) push_wr(a, FILL);
        @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        count_low(1100, n);
        checks++;
        if (n != 1000) begin
            errors++;
            $display("FAIL clear_len: ready low for %0d cycles, required 1000", n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL clear_writes: %0d writes missing, required 0", exp_q.size());
        end
        exp_col = 0;
        exp_row = 0;
    endtask

    task automatic test_print();
        int n;
        push_wr(0, 8'h48);
        send(8'h48);
        count_low(10, n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL print_gap_h: busy %0d cycles, required 1", n);
        end
        push_wr(1, 8'h69);
        send(8'h69);
        count_low(10, n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL print_gap_i: busy %0d cycles, required 1", n);
        end
        exp_col = 2;
        checks++;
        if (int'(cursor_col) != exp_col || int'(cursor_row) != exp_row) begin
            errors++;
            $display("FAIL print_cursor: %0d/%0d, required %0d/%0d",
                     cursor_row, cursor_col, exp_row, exp_col);
        end
    endtask

    task automatic test_back_to_back();
        int    n;
        longint t;
        longint prev;
        logic [7:0] chars [3];
        chars[0] = 8'h31;
        chars[1] = 8'h32;
        chars[2] = 8'h33;
        for (int i = 0; i < 3; i++) push_wr(2 + i, chars[i]);
        prev = 0;
        @(negedge clk);
        bus.char_in    = chars[0];
        bus.char_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!bus.char_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            t = $time;
            @(negedge clk);
            if (i < 2) bus.char_in = chars[i + 1];
            if (i > 0) begin
                checks++;
                if (t - prev != 64'd20) begin
                    errors++;
                    $display("FAIL b2b_spacing: accepts %0d ns apart, required 20", t - prev);
                end
            end
            prev = t;
        end
        bus.char_valid = 1'b0;
        count_low(10, n);
        exp_col = 5;
        checks++;
        if (exp_q.size() != 0 || int'(cursor_col) != exp_col) begin
            errors++;
            $display("FAIL b2b_result: pending=%0d col=%0d, required 0 and %0d",
                     exp_q.size(), cursor_col, exp_col);
        end
    endtask

    task automatic test_wrap();
        int n;
        send(8'h0D);
        count_low(10, n);
        exp_col = 0;
        checks++;
        if (n != 1 || int'(cursor_col) != 0) begin
            errors++;
            $display("FAIL cr: gap=%0d col=%0d, required 1 and 0", n, cursor_col);
        end
        for (int i = 0; i < 3; i++) begin
            send(8'h0A);
            count_low(10, n);
        end
        exp_row = 3;
        send(8'h01);
        count_low(10, n);
        checks++;
        if (n != 1 || int'(cursor_row) != 3 || int'(cursor_col) != 0) begin
            errors++;
            $display("FAIL ignored: gap=%0d cursor=%0d/%0d, required 1 and 3/0",
                     n, cursor_row, cursor_col);
        end
        for (int c = 0; c < 39; c++) begin
            push_wr(120 + c, 8'h61 + 8'(c % 26));
            send(8'h61 + 8'(c % 26));
            count_low(10, n);
        end
        push_wr(159, 8'h5A);
        send(8'h5A);
        count_low(10, n);
        exp_row = 4;
        exp_col = 0;
        checks++;
        if (n != 1 || int'(cursor_row) != exp_row || int'(cursor_col) != exp_col) begin
            errors++;
            $display("FAIL wrap: gap=%0d cursor=%0d/%0d, required 1 and 4/0",
                     n, cursor_row, cursor_col);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_writes: %0d writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_backspace();
        int n;
        send(8'h0A);
        count_low(10, n);
        for (int c = 0; c < 10; c++) begin
            push_wr(200 + c, 8'h62);
            send(8'h62);
            count_low(10, n);
        end
        push_wr(209, FILL);
        send(8'h08);
        count_low(10, n);
        checks++;
        if (n != 1 || int'(cursor_row) != 5 || int'(cursor_col) != 9 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bs: gap=%0d cursor=%0d/%0d pending=%0d, required 1, 5/9, 0",
                     n, cursor_row, cursor_col, exp_q.size());
        end
        send(8'h0D);
        count_low(10, n);
        send(8'h08);
        count_low(10, n);
        checks++;
        if (n != 1 || int'(cursor_row) != 5 || int'(cursor_col) != 0) begin
            errors++;
            $display("FAIL bs_col0: gap=%0d cursor=%0d/%0d, required 1 and 5/0",
                     n, cursor_row, cursor_col);
        end
        exp_row = 5;
        exp_col = 0;
    endtask

    task automatic push_scroll();
        for (int a = 0; a < int'((ROWS - 1) * COLS); a++) push_wr(a, exp_mem[a + int'(COLS)]);
        for (int a = int'((ROWS - 1) * COLS); a < int'(CELLS); a++) push_wr(a, FILL);
    endtask

    task automatic test_scroll();
        int n;
        @(negedge clk);
        mem[40]     <= 8'h41;
        exp_mem[40] = 8'h41;
        for (int i = 0; i < 19; i++) begin
            send(8'h0A);
            count_low(10, n);
        end
        checks++;
        if (int'(cursor_row) != 24) begin
            errors++;
            $display("FAIL to_last_row: row=%0d, required 24", cursor_row);
        end
        push_scroll();
        send(8'h0A);
        count_low(3000, n);
        checks++;
        if (n != 1960) begin
            errors++;
            $display("FAIL scroll_len: busy %0d cycles, required 1960", n);
        end
        checks++;
        if (int'(cursor_row) != 24 || int'(cursor_col) != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL scroll_end: cursor=%0d/%0d pending=%0d, required 24/0 and 0",
                     cursor_row, cursor_col, exp_q.size());
        end
        checks++;
        if (mem[0] !== 8'h41) begin
            errors++;
            $display("FAIL scroll_ram0: ram[0]=%h, required 41", mem[0]);
        end
    endtask

    task automatic test_formfeed();
        int n;
        for (int a = 0; a < int'(CELLS); a++) push_wr(a, FILL);
        send(8'h0C);
        count_low(1100, n);
        checks++;
        if (n != 1000 || cursor_row !== 5'd0 || cursor_col !== 6'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ff: busy=%0d cursor=%0d/%0d pending=%0d, required 1000, 0/0, 0",
                     n, cursor_row, cursor_col, exp_q.size());
        end
    endtask

    task automatic test_reset_midscroll();
        int n;
        for (int i = 0; i < 24; i++) begin
            send(8'h0A);
            count_low(10, n);
        end
        push_scroll();
        send(8'h0A);
        repeat (500) @(negedge clk);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (bus.ram_we !== 1'b0 || bus.char_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_ctl: we=%b ready=%b busy=%b, required 0 0 1",
                     bus.ram_we, bus.char_ready, busy);
        end
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 6'd0 || bus.ram_addr !== '0) begin
            errors++;
            $display("FAIL abort_state: cursor=%0d/%0d addr=%0d, required 0/0 and 0",
                     cursor_row, cursor_col, bus.ram_addr);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        for (int a = 0; a < int'(CELLS); a++) push_wr(a, FILL);
        @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        count_low(1100, n);
        checks++;
        if (n != 1000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL post_abort_clear: ready low %0d cycles pending=%0d, required 1000 and 0",
                     n, exp_q.size());
        end
        checks++;
        if (cursor_row !== 5'd0 || cursor_col !== 6'd0) begin
            errors++;
            $display("FAIL post_abort_cursor: %0d/%0d, required 0/0", cursor_row, cursor_col);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_print();
        test_back_to_back();
        test_wrap();
        test_backspace();
        test_scroll();
        test_formfeed();
        test_reset_midscroll();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
